// File: rtl/shading_pkg.sv
// Shared widths, dither matrix and raw texel expansion for the shading pipe.
package shading_pkg;

    localparam int TEXW_DEF = 5;
    localparam int GW_DEF   = 9;

    // Ordered 4x4 dither offsets, indexed [y][x].
    localparam logic signed [3:0] DITHER [4][4] = '{
        '{-4'sd4,  4'sd0, -4'sd3,  4'sd1},
        '{ 4'sd2, -4'sd2,  4'sd3, -4'sd1},
        '{-4'sd3,  4'sd1, -4'sd4,  4'sd0},
        '{ 4'sd3, -4'sd1,  4'sd2, -4'sd2}
    };

    // Left-justify a texel into a wider colour channel, zero-filling the LSBs.
    function automatic logic [15:0] raw_expand(input logic [15:0] t, input int sh);
        return t << sh;
    endfunction

endpackage

// File: rtl/shading_channel.sv
// One colour channel: S1 texel select + multiply, S2 scale/clamp (and dither when
// SHADING_PIPE_DITHER_EN is defined). Handshake is owned by the parent.
module shading_channel
    import shading_pkg::*;
#(
    parameter int TEXW = TEXW_DEF,
    parameter int GW   = GW_DEF
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ld1,
    input  logic            ld2,
    input  logic [TEXW-1:0] tex_i,
    input  logic [GW-1:0]   g_i,
    input  logic            notex_i,
    input  logic            raw_s1_i,
`ifdef SHADING_PIPE_DITHER_EN
    input  logic            dith_on_s1_i,
    input  logic [3:0]      dith_d_s1_i,
`endif
    output logic [GW-2:0]   color_o
);

    localparam int OUTW = GW - 1;
    localparam int PW   = TEXW + GW;

    logic [TEXW-1:0] t_d, t_q;
    logic [GW-1:0]   s_d, s_q;
    logic [OUTW-1:0] raw_res, mod_res, color_d, color_q;
`ifdef SHADING_PIPE_DITHER_EN
    localparam int SW = GW + 2;
    logic [SW-1:0]   sum;
`endif

    always_comb begin
        t_d = notex_i ? '1 : tex_i;
        s_d = GW'((PW'(g_i) * PW'(t_d)) >> TEXW);
    end

    always_comb begin
        raw_res = OUTW'(raw_expand(16'(t_q), OUTW - TEXW));
`ifdef SHADING_PIPE_DITHER_EN
        // One spare bit of headroom so a positive offset near full scale saturates instead of wrapping.
        sum = {2'b00, s_q} + (dith_on_s1_i ? {{(SW-4){dith_d_s1_i[3]}}, dith_d_s1_i} : '0);
        if (sum[SW-1])
            mod_res = '0;
        else if (|sum[SW-2:OUTW])
            mod_res = '1;
        else
            mod_res = sum[OUTW-1:0];
`else
        mod_res = s_q[GW-1] ? '1 : s_q[OUTW-1:0];
`endif
        color_d = raw_s1_i ? raw_res : mod_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q     <= '0;
            s_q     <= '0;
            color_q <= '0;
        end else begin
            if (ld1) begin
                t_q <= t_d;
                s_q <= s_d;
            end
            if (ld2)
                color_q <= color_d;
        end
    end

    assign color_o = color_q;

endmodule

// File: rtl/shading_pipe.sv
// Two-stage Gouraud x texel shading pipe with valid/ready on both sides.
// Optional ordered dither is compiled in with SHADING_PIPE_DITHER_EN.
module shading_pipe
    import shading_pkg::*;
#(
    parameter int NCH  = 3,
    parameter int TEXW = TEXW_DEF,
    parameter int GW   = GW_DEF,
    parameter int TAGW = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [NCH*TEXW-1:0]   i_tex,
    input  logic [NCH*GW-1:0]     i_gouraud,
    input  logic                  i_noTexture,
    input  logic                  i_rawTex,
    input  logic                  i_ditherOn,
    input  logic [1:0]            i_x,
    input  logic [1:0]            i_y,
    input  logic [TAGW-1:0]       i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NCH*(GW-1)-1:0] o_color,
    output logic [TAGW-1:0]       o_tag
);

    localparam int OUTW = GW - 1;

    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d;
    logic            raw_q;
    logic [TAGW-1:0] tag1_q, tag2_q;
    logic            s2_adv, ld1, ld2;

    // No skid buffer: upstream ready follows downstream ready combinationally.
    assign s2_adv  = !s2_valid_q || i_ready;
    assign o_ready = !s1_valid_q || s2_adv;
    assign ld1     = i_valid && o_ready;
    assign ld2     = s1_valid_q && s2_adv;

    always_comb begin
        s1_valid_d = o_ready ? i_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            raw_q      <= 1'b0;
            tag1_q     <= '0;
            tag2_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (ld1) begin
                raw_q  <= i_rawTex;
                tag1_q <= i_tag;
            end
            if (ld2)
                tag2_q <= tag1_q;
        end
    end

`ifdef SHADING_PIPE_DITHER_EN
    logic       don_q;
    logic [1:0] x_q, y_q;
    logic       dith_on;
    logic [3:0] dith_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            don_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
        end else if (ld1) begin
            don_q <= i_ditherOn;
            x_q   <= i_x;
            y_q   <= i_y;
        end
    end

    assign dith_on = don_q && !raw_q;
    assign dith_d  = DITHER[y_q][x_q];
`else
    logic unused_dither;
    assign unused_dither = ^{i_ditherOn, i_x, i_y};
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        shading_channel #(
            .TEXW (TEXW),
            .GW   (GW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .ld1          (ld1),
            .ld2          (ld2),
            .tex_i        (i_tex[c*TEXW +: TEXW]),
            .g_i          (i_gouraud[c*GW +: GW]),
            .notex_i      (i_noTexture),
            .raw_s1_i     (raw_q),
`ifdef SHADING_PIPE_DITHER_EN
            .dith_on_s1_i (dith_on),
            .dith_d_s1_i  (dith_d),
`endif
            .color_o      (o_color[c*OUTW +: OUTW])
        );
    end

    assign o_valid = s2_valid_q;
    assign o_tag   = tag2_q;

endmodule

// File: tb/tb_shading_pipe.sv
// Self-checking bench for shading_pipe: directed cases, throughput, backpressure,
// mid-flight reset and a randomized stream against an integer reference model.
module tb_shading_pipe;

    localparam int NCH  = 3;
    localparam int TEXW = 5;
    localparam int GW   = 9;
    localparam int TAGW = 16;
    localparam int OUTW = GW - 1;
`ifdef SHADING_PIPE_DITHER_EN
    localparam bit DITHER_ON = 1'b1;
`else
    localparam bit DITHER_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_valid;
    logic                 o_ready;
    logic [NCH*TEXW-1:0]  i_tex;
    logic [NCH*GW-1:0]    i_gouraud;
    logic                 i_noTexture, i_rawTex, i_ditherOn;
    logic [1:0]           i_x, i_y;
    logic [TAGW-1:0]      i_tag;
    logic                 o_valid;
    logic                 i_ready;
    logic [NCH*OUTW-1:0]  o_color;
    logic [TAGW-1:0]      o_tag;

    int n_checks = 0;
    int n_fail   = 0;

    int dmat [4][4] = '{'{-4, 0, -3, 1}, '{2, -2, 3, -1}, '{-3, 1, -4, 0}, '{3, -1, 2, -2}};

    typedef struct {
        logic [NCH*OUTW-1:0] color;
        logic [TAGW-1:0]     tag;
    } exp_t;

    typedef struct {
        logic [NCH*TEXW-1:0] tex;
        logic [NCH*GW-1:0]   g;
        bit                  notex;
        bit                  raw;
        bit                  don;
        logic [1:0]          x;
        logic [1:0]          y;
        logic [NCH*OUTW-1:0] exp_c;
    } dcase_t;

    exp_t q[$];

    always #5 clk = ~clk;

    shading_pipe #(.NCH(NCH), .TEXW(TEXW), .GW(GW), .TAGW(TAGW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_tex       (i_tex),
        .i_gouraud   (i_gouraud),
        .i_noTexture (i_noTexture),
        .i_rawTex    (i_rawTex),
        .i_ditherOn  (i_ditherOn),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_tag       (i_tag),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_color     (o_color),
        .o_tag       (o_tag)
    );

    // Reference: plain integer arithmetic on channel values.
    function automatic int chan_model(int t_in, int g, bit notex, bit raw, bit don, int x, int y);
        int t, v;
        t = notex ? (2**TEXW - 1) : t_in;
        if (raw) return t * (2**(OUTW - TEXW));
        v = (g * t) / (2**TEXW);
        if (DITHER_ON && don) v = v + dmat[y][x];
        if (v < 0) v = 0;
        if (v > 2**OUTW - 1) v = 2**OUTW - 1;
        return v;
    endfunction

    function automatic logic [NCH*OUTW-1:0] pix_model(logic [NCH*TEXW-1:0] tex, logic [NCH*GW-1:0] g,
                                                      bit notex, bit raw, bit don, logic [1:0] x, logic [1:0] y);
        logic [NCH*OUTW-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++)
            r[c*OUTW +: OUTW] = OUTW'(chan_model(int'(tex[c*TEXW +: TEXW]), int'(g[c*GW +: GW]),
                                                 notex, raw, don, int'(x), int'(y)));
        return r;
    endfunction

    function automatic logic [NCH*TEXW-1:0] rt(int v);
        return {NCH{TEXW'(v)}};
    endfunction

    function automatic logic [NCH*GW-1:0] rg(int v);
        return {NCH{GW'(v)}};
    endfunction

    function automatic logic [NCH*OUTW-1:0] ro(int v);
        return {NCH{OUTW'(v)}};
    endfunction

    task automatic idle_inputs();
        i_valid     = 1'b0;
        i_tex       = '0;
        i_gouraud   = '0;
        i_noTexture = 1'b0;
        i_rawTex    = 1'b0;
        i_ditherOn  = 1'b0;
        i_x         = '0;
        i_y         = '0;
        i_tag       = '0;
        i_ready     = 1'b1;
    endtask

    // Streams n random pixels under random valid/ready and scoreboards every output.
    task automatic run_stream(input int n, input int valid_pct, input int ready_pct,
                              input int tag_base, output int cycles);
        bit                  pend, stall_prev;
        int                  sent, recv;
        logic [NCH*OUTW-1:0] prev_color;
        logic [TAGW-1:0]     prev_tag;
        exp_t                e;
        pend = 0; stall_prev = 0; sent = 0; recv = 0; cycles = 0;
        prev_color = '0; prev_tag = '0;
        while (recv < n && cycles < n * 20 + 50) begin
            @(negedge clk);
            if (!pend && sent < n && $urandom_range(99) < valid_pct) begin
                i_tex = (NCH*TEXW)'($urandom);
                for (int c = 0; c < NCH; c++)
                    i_gouraud[c*GW +: GW] = GW'($urandom_range(0, 2**GW - 1));
                i_noTexture = ($urandom_range(3) == 0);
                i_rawTex    = ($urandom_range(3) == 0);
                i_ditherOn  = 1'($urandom);
                i_x         = 2'($urandom);
                i_y         = 2'($urandom);
                i_tag       = TAGW'(tag_base + sent);
                pend = 1;
            end
            i_valid = pend;
            i_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (stall_prev) begin
                n_checks++;
                if (o_valid !== 1'b1 || o_color !== prev_color || o_tag !== prev_tag) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b c=%h t=%h want v=1 c=%h t=%h",
                             o_valid, o_color, o_tag, prev_color, prev_tag);
                end
            end
            if (o_valid && i_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got tag=%h want no output", o_tag);
                end else begin
                    e = q.pop_front();
                    if (o_color !== e.color || o_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL stream_out: got c=%h t=%h want c=%h t=%h",
                                 o_color, o_tag, e.color, e.tag);
                    end
                end
                recv++;
            end
            if (i_valid && o_ready) begin
                e.color = pix_model(i_tex, i_gouraud, i_noTexture, i_rawTex, i_ditherOn, i_x, i_y);
                e.tag   = i_tag;
                q.push_back(e);
                sent++;
                pend = 0;
            end
            stall_prev = o_valid && !i_ready;
            prev_color = o_color;
            prev_tag   = o_tag;
            cycles++;
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_checks++;
        if (recv != n || q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: got recv=%0d left=%0d want recv=%0d left=0", recv, q.size(), n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o_color !== '0) begin n_fail++; $display("FAIL reset_color: got %h want 0", o_color); end
        n_checks++;
        if (o_tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", o_tag); end
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_directed();
        dcase_t tbl[$];
        tbl.push_back('{rt(31), rg(256), 0, 0, 0, 2'd0, 2'd0, ro(248)});
        tbl.push_back('{rt(31), rg(511), 0, 0, 0, 2'd0, 2'd0, ro(255)});
        tbl.push_back('{rt(16), rg(128), 0, 0, 0, 2'd0, 2'd0, ro(64)});
        tbl.push_back('{rt(31), rg(0),   0, 0, 0, 2'd0, 2'd0, ro(0)});
        tbl.push_back('{rt(0),  rg(256), 1, 0, 0, 2'd0, 2'd0, ro(248)});
        tbl.push_back('{rt(31), rg(0),   0, 1, 0, 2'd0, 2'd0, ro(248)});
        tbl.push_back('{rt(1),  rg(300), 0, 1, 0, 2'd0, 2'd0, ro(8)});
        tbl.push_back('{rt(0),  rg(77),  1, 1, 0, 2'd0, 2'd0, ro(248)});
        tbl.push_back('{{5'd31, 5'd16, 5'd31}, {9'd511, 9'd128, 9'd256}, 0, 0, 0, 2'd0, 2'd0,
                        {8'd255, 8'd64, 8'd248}});
        tbl.push_back('{rt(31), rg(256), 0, 0, 1, 2'd0, 2'd0, ro(DITHER_ON ? 244 : 248)});
        tbl.push_back('{rt(31), rg(256), 0, 0, 1, 2'd2, 2'd1, ro(DITHER_ON ? 251 : 248)});
        tbl.push_back('{rt(0),  rg(0),   0, 0, 1, 2'd0, 2'd0, ro(0)});
        tbl.push_back('{rt(31), rg(256), 0, 0, 0, 2'd2, 2'd1, ro(248)});
        tbl.push_back('{rt(31), rg(0),   0, 1, 1, 2'd0, 2'd0, ro(248)});
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            i_tex       = tbl[k].tex;
            i_gouraud   = tbl[k].g;
            i_noTexture = tbl[k].notex;
            i_rawTex    = tbl[k].raw;
            i_ditherOn  = tbl[k].don;
            i_x         = tbl[k].x;
            i_y         = tbl[k].y;
            i_tag       = TAGW'(16'hA000 + k);
            i_valid     = 1'b1;
            i_ready     = 1'b1;
            #1;
            n_checks++;
            if (o_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready case %0d: got %b want 1", k, o_ready); end
            @(negedge clk);
            i_valid = 1'b0;
            i_noTexture = 1'b0;
            i_rawTex    = 1'b0;
            i_ditherOn  = 1'b0;
            #1;
            n_checks++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL dir_early case %0d: got o_valid=%b want 0", k, o_valid); end
            @(negedge clk);
            #1;
            n_checks++;
            if (o_valid !== 1'b1 || o_color !== tbl[k].exp_c || o_tag !== TAGW'(16'hA000 + k)) begin
                n_fail++;
                $display("FAIL dir_result case %0d: got v=%b c=%h t=%h want v=1 c=%h t=%h",
                         k, o_valid, o_color, o_tag, tbl[k].exp_c, TAGW'(16'hA000 + k));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_stream(8, 100, 100, 16'h1000, cyc);
        n_checks++;
        if (cyc != 10) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 10", cyc); end
    endtask

    task automatic test_backpressure();
        int cyc;
        run_stream(8, 100, 50, 16'h2000, cyc);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        i_ready = 1'b0;
        i_tex = rt(31); i_gouraud = rg(256);
        i_tag = 16'hDEA0; i_valid = 1'b1;
        @(negedge clk);
        i_tag = 16'hDEA1;
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_color !== '0) begin
            n_fail++;
            $display("FAIL midrst_flush: got v=%b c=%h want v=0 c=0", o_valid, o_color);
        end
        rst = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_ghost: got o_valid=%b tag=%h want 0", o_valid, o_tag);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        run_stream(300, 70, 60, 16'h4000, cyc);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
